// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the PIC16F fetch sequencer: NOP encoding, Q-phase values,
// default reset/interrupt vectors and field widths.
package fetch_sequencer_pkg;

  localparam int unsigned InstrWidth   = 14;
  localparam int unsigned JumpLitWidth = 11;
  localparam int unsigned DefPcWidth   = 13;

  localparam logic [InstrWidth-1:0] Nop = 14'h0000;

  // Q phases of the four-clock instruction cycle.
  localparam logic [1:0] QPh1 = 2'd0;
  localparam logic [1:0] QPh2 = 2'd1;
  localparam logic [1:0] QPh3 = 2'd2;
  localparam logic [1:0] QPh4 = 2'd3;

  localparam logic [DefPcWidth-1:0] DefResetVector = 13'h000;
  localparam logic [DefPcWidth-1:0] DefIrqVector   = 13'h004;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between fetch_sequencer, program memory, instruction_decoder and the call stack.
// Modports:
//   master - the sequencer: drives q_count, prog_addr, instr_current, irq_ack,
//            stack_push, stack_data; samples stall, prog_data, decoder requests, irq/gie.
//   slave  - the surrounding core (memory, decoder, stack, interrupt logic).
interface fetch_sequencer_if #(
  parameter int unsigned PC_WIDTH = 13
);
  import fetch_sequencer_pkg::*;

  logic                    stall;
  logic [1:0]              q_count;
  logic [PC_WIDTH-1:0]     prog_addr;
  logic [InstrWidth-1:0]   prog_data;
  logic [InstrWidth-1:0]   instr_current;
  logic                    instr_rd_en;
  logic                    instr_flush;
  logic                    pc_incr_en;
  logic                    pc_j_en;
  logic [JumpLitWidth-1:0] pc_j_addr;
  logic [1:0]              pclath_hi;
  logic                    irq;
  logic                    gie;
  logic                    irq_ack;
  logic                    stack_push;
  logic [PC_WIDTH-1:0]     stack_data;

  modport master (
    input  stall, prog_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_j_addr,
           pclath_hi, irq, gie,
    output q_count, prog_addr, instr_current, irq_ack, stack_push, stack_data
  );

  modport slave (
    output stall, prog_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_j_addr,
           pclath_hi, irq, gie,
    input  q_count, prog_addr, instr_current, irq_ack, stack_push, stack_data
  );

endinterface

// File: rtl/fetch_sequencer_q_phase_counter.sv
// Q-phase counter: 2-bit mod-4 counter with synchronous active-high reset and a hold
// enable. q_last_o flags the Q4 phase.
// Ports: clk, rst, hold_i (freeze count), q_count_o (phase 0..3), q_last_o (phase == Q4).
module fetch_sequencer_q_phase_counter
  import fetch_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_i,
  output logic [1:0] q_count_o,
  output logic       q_last_o
);

  logic [1:0] q_d, q_q;

  always_comb begin
    q_d = hold_i ? q_q : q_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= QPh1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_count_o = q_q;
  assign q_last_o  = (q_q == QPh4);

endmodule

// File: rtl/fetch_sequencer.sv
// PIC16F fetch sequencer: owns Q-phase counter, PC and IR, and applies the decoder's
// requests at Q4 (jump/flush/load/increment, optional interrupt vectoring).
// Ports: clk, rst (synchronous, active high), bus (fetch_sequencer_if.master).
// Build option: define FETCH_SEQ_IRQ_EN to enable interrupt entry; otherwise irq/gie
// are ignored and irq_ack/stack_push stay 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 13,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DefResetVector),
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(DefIrqVector)
) (
  input logic                clk,
  input logic                rst,
  fetch_sequencer_if.master  bus
);

  logic                  q_last;
  logic                  q4;
  logic                  irq_take;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic [InstrWidth-1:0] ir_d, ir_q;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   pc_jump;

  fetch_sequencer_q_phase_counter u_q_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (bus.stall),
    .q_count_o (bus.q_count),
    .q_last_o  (q_last)
  );

  // Requests only act in an unstalled Q4 clock; reset overrides everything.
  assign q4      = q_last & ~bus.stall & ~rst;
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign pc_jump = PC_WIDTH'({bus.pclath_hi, bus.pc_j_addr});

`ifdef FETCH_SEQ_IRQ_EN
  // A coincident jump wins; the interrupt is retaken next Q4 and pushes the target.
  assign irq_take = q4 & bus.irq & bus.gie & ~bus.pc_j_en;
`else
  logic unused_irq;
  assign unused_irq = bus.irq ^ bus.gie;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (q4) begin
      if (bus.pc_j_en) begin
        pc_d = pc_jump;
        ir_d = Nop;
      end else if (irq_take) begin
        pc_d = IRQ_VECTOR;
        ir_d = Nop;
      end else if (bus.instr_flush) begin
        ir_d = Nop;
        if (bus.pc_incr_en) pc_d = pc_inc;
      end else if (bus.instr_rd_en) begin
        ir_d = bus.prog_data;
        if (bus.pc_incr_en) pc_d = pc_inc;
      end else if (bus.pc_incr_en) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
      ir_q <= Nop;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign bus.prog_addr     = pc_q;
  assign bus.stack_data    = pc_q;
  assign bus.instr_current = ir_q;
  assign bus.irq_ack       = irq_take;
  assign bus.stack_push    = irq_take;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [13:0] mem [0:8191];

  fetch_sequencer_if #(.PC_WIDTH(13)) bus ();

  fetch_sequencer #(
    .PC_WIDTH     (13),
    .RESET_VECTOR (13'h000),
    .IRQ_VECTOR   (13'h004)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.prog_data = mem[bus.prog_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a jump request at the next Q4; assumes current phase is Q1.
  task automatic do_jump(input logic [1:0] hi, input logic [10:0] lit);
    ticks(3);
    bus.pclath_hi = hi;
    bus.pc_j_addr = lit;
    bus.pc_j_en   = 1'b1;
    ticks(1);
    bus.pc_j_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    total_cnt++;
    if (bus.q_count !== 2'd0) $display("FAIL reset_q: got %0d want 0", bus.q_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.prog_addr !== 13'h000) $display("FAIL reset_pc: got %h want 000", bus.prog_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.instr_current !== 14'h0000)
      $display("FAIL reset_ir: got %h want 0000", bus.instr_current);
    else pass_cnt++;
    total_cnt++;
    if (bus.irq_ack !== 1'b0 || bus.stack_push !== 1'b0 || bus.stack_data !== 13'h000)
      $display("FAIL reset_irq_out: got ack=%b push=%b data=%h want 0 0 000",
               bus.irq_ack, bus.stack_push, bus.stack_data);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    ticks(1);
    total_cnt++;
    if (bus.q_count !== 2'd1 || bus.prog_addr !== 13'h000 || bus.instr_current !== 14'h0000)
      $display("FAIL seq_q2: got q=%0d pc=%h ir=%h want 1 000 0000",
               bus.q_count, bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    ticks(3);
    total_cnt++;
    if (bus.q_count !== 2'd0 || bus.prog_addr !== 13'h001 || bus.instr_current !== 14'h3011)
      $display("FAIL seq_first: got q=%0d pc=%h ir=%h want 0 001 3011",
               bus.q_count, bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    ticks(12);
    total_cnt++;
    if (bus.prog_addr !== 13'h004 || bus.instr_current !== 14'h3044)
      $display("FAIL seq_clk16: got pc=%h ir=%h want 004 3044",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    ticks(4);  // IR=mem[4], PC=5
    ticks(4);  // IR=GOTO from mem[5], PC=6
    total_cnt++;
    if (bus.prog_addr !== 13'h006 || bus.instr_current !== 14'h2923)
      $display("FAIL jump_goto_in_ir: got pc=%h ir=%h want 006 2923",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    // Jump request outside Q4 must be ignored.
    bus.pclath_hi = 2'b01;
    bus.pc_j_addr = 11'h123;
    bus.pc_j_en   = 1'b1;
    ticks(3);
    total_cnt++;
    if (bus.prog_addr !== 13'h006 || bus.q_count !== 2'd3)
      $display("FAIL jump_non_q4: got pc=%h q=%0d want 006 3", bus.prog_addr, bus.q_count);
    else pass_cnt++;
    ticks(1);
    bus.pc_j_en = 1'b0;
    total_cnt++;
    if (bus.prog_addr !== 13'h0923 || bus.instr_current !== 14'h0000)
      $display("FAIL jump_target: got pc=%h ir=%h want 0923 0000",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    ticks(4);
    total_cnt++;
    if (bus.prog_addr !== 13'h0924 || bus.instr_current !== 14'h30ab)
      $display("FAIL jump_fetch: got pc=%h ir=%h want 0924 30ab",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    ticks(1);
    bus.stall = 1'b1;
    ticks(6);
    total_cnt++;
    if (bus.q_count !== 2'd1 || bus.prog_addr !== 13'h0924 || bus.instr_current !== 14'h30ab)
      $display("FAIL stall_hold: got q=%0d pc=%h ir=%h want 1 0924 30ab",
               bus.q_count, bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    bus.stall = 1'b0;
    ticks(2);
    bus.stall = 1'b1;
    ticks(2);
    total_cnt++;
    if (bus.q_count !== 2'd3 || bus.prog_addr !== 13'h0924 || bus.instr_current !== 14'h30ab)
      $display("FAIL stall_q4: got q=%0d pc=%h ir=%h want 3 0924 30ab",
               bus.q_count, bus.prog_addr, bus.instr_current);
    else pass_cnt++;
    bus.stall = 1'b0;
    ticks(1);
    total_cnt++;
    if (bus.q_count !== 2'd0 || bus.prog_addr !== 13'h0925 || bus.instr_current !== 14'h30cd)
      $display("FAIL stall_resume: got q=%0d pc=%h ir=%h want 0 0925 30cd",
               bus.q_count, bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    ticks(3);
    bus.instr_flush = 1'b1;
    ticks(1);
    bus.instr_flush = 1'b0;
    total_cnt++;
    if (bus.prog_addr !== 13'h0926 || bus.instr_current !== 14'h0000)
      $display("FAIL flush: got pc=%h ir=%h want 0926 0000",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_jump(2'b11, 11'h7ff);
    total_cnt++;
    if (bus.prog_addr !== 13'h1fff)
      $display("FAIL wrap_setup: got pc=%h want 1fff", bus.prog_addr);
    else pass_cnt++;
    ticks(4);
    total_cnt++;
    if (bus.prog_addr !== 13'h0000 || bus.instr_current !== 14'h30ee)
      $display("FAIL wrap: got pc=%h ir=%h want 0000 30ee",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    do_jump(2'b00, 11'h010);
    ticks(3);
    bus.irq = 1'b1;
    bus.gie = 1'b1;
    #1;
`ifdef FETCH_SEQ_IRQ_EN
    total_cnt++;
    if (bus.stack_push !== 1'b1 || bus.irq_ack !== 1'b1 || bus.stack_data !== 13'h010)
      $display("FAIL irq_entry: got push=%b ack=%b data=%h want 1 1 010",
               bus.stack_push, bus.irq_ack, bus.stack_data);
    else pass_cnt++;
    ticks(1);
    bus.gie = 1'b0;
    total_cnt++;
    if (bus.prog_addr !== 13'h004 || bus.instr_current !== 14'h0000 || bus.stack_push !== 1'b0)
      $display("FAIL irq_vector: got pc=%h ir=%h push=%b want 004 0000 0",
               bus.prog_addr, bus.instr_current, bus.stack_push);
    else pass_cnt++;
    // Jump coincident with interrupt: jump first, push the target next Q4.
    ticks(3);
    bus.pclath_hi = 2'b00;
    bus.pc_j_addr = 11'h050;
    bus.pc_j_en   = 1'b1;
    bus.gie       = 1'b1;
    #1;
    total_cnt++;
    if (bus.stack_push !== 1'b0 || bus.irq_ack !== 1'b0)
      $display("FAIL irq_vs_jump: got push=%b ack=%b want 0 0", bus.stack_push, bus.irq_ack);
    else pass_cnt++;
    ticks(1);
    bus.pc_j_en = 1'b0;
    total_cnt++;
    if (bus.prog_addr !== 13'h050)
      $display("FAIL irq_jump_target: got pc=%h want 050", bus.prog_addr);
    else pass_cnt++;
    ticks(3);
    #1;
    total_cnt++;
    if (bus.stack_push !== 1'b1 || bus.stack_data !== 13'h050)
      $display("FAIL irq_deferred: got push=%b data=%h want 1 050",
               bus.stack_push, bus.stack_data);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (bus.prog_addr !== 13'h004)
      $display("FAIL irq_deferred_vec: got pc=%h want 004", bus.prog_addr);
    else pass_cnt++;
`else
    total_cnt++;
    if (bus.stack_push !== 1'b0 || bus.irq_ack !== 1'b0)
      $display("FAIL irq_disabled: got push=%b ack=%b want 0 0", bus.stack_push, bus.irq_ack);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (bus.prog_addr !== 13'h011 || bus.instr_current !== 14'h3010)
      $display("FAIL irq_ignored: got pc=%h ir=%h want 011 3010",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
`endif
    bus.irq = 1'b0;
    bus.gie = 1'b0;
  endtask

  task automatic test_reset_mid_jump();
    do_jump(2'b00, 11'h200);
    total_cnt++;
    if (bus.prog_addr !== 13'h200)
      $display("FAIL rstmid_setup: got pc=%h want 200", bus.prog_addr);
    else pass_cnt++;
    ticks(1);  // now Q2
    rst       = 1'b1;
    bus.stall = 1'b1;
    bus.irq   = 1'b1;
    bus.gie   = 1'b1;
    ticks(1);
    total_cnt++;
    if (bus.q_count !== 2'd0 || bus.prog_addr !== 13'h000 || bus.instr_current !== 14'h0000 ||
        bus.stack_push !== 1'b0)
      $display("FAIL rstmid: got q=%0d pc=%h ir=%h push=%b want 0 000 0000 0",
               bus.q_count, bus.prog_addr, bus.instr_current, bus.stack_push);
    else pass_cnt++;
    rst       = 1'b0;
    bus.stall = 1'b0;
    bus.irq   = 1'b0;
    bus.gie   = 1'b0;
    ticks(4);
    total_cnt++;
    if (bus.prog_addr !== 13'h001 || bus.instr_current !== 14'h3011)
      $display("FAIL rstmid_restart: got pc=%h ir=%h want 001 3011",
               bus.prog_addr, bus.instr_current);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 14'h0000;
    mem[0]       = 14'h3011;
    mem[1]       = 14'h3022;
    mem[2]       = 14'h3033;
    mem[3]       = 14'h3044;
    mem[4]       = 14'h3055;
    mem[5]       = 14'h2923;  // GOTO 0x123
    mem[13'h010] = 14'h3010;
    mem[13'h923] = 14'h30ab;
    mem[13'h924] = 14'h30cd;
    mem[13'h1fff] = 14'h30ee;

    bus.stall       = 1'b0;
    bus.instr_rd_en = 1'b1;
    bus.pc_incr_en  = 1'b1;
    bus.instr_flush = 1'b0;
    bus.pc_j_en     = 1'b0;
    bus.pc_j_addr   = 11'h000;
    bus.pclath_hi   = 2'b00;
    bus.irq         = 1'b0;
    bus.gie         = 1'b0;

    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_flush();
    test_wrap();
    test_irq();
    test_reset_mid_jump();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
